dmem_arb: RTL and testbench
===========================

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning data memory size in bytes; addresses >= MEM_BYTES are out of range.
REQ-002 SHALL have parameter DEBUG_PRIO, default 0, meaning 0 = round-robin arbitration, 1 = requester 1 has fixed priority.
REQ-003 SHALL have port CLK  in  1  single clock, rising edge.
REQ-004 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reqN_valid  in  1  request present (N=0 core LSU, N=1 debug/loader).
REQ-006 SHALL have ports reqN_ready  out  1  request accepted this cycle.
REQ-007 SHALL have ports reqN_addr  in  32  byte address.
REQ-008 SHALL have ports reqN_wdata  in  32  store data, LSB-aligned.
REQ-009 SHALL have ports reqN_ctrl  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have ports reqN_wen  in  1  1 = store, 0 = load.
REQ-011 SHALL have ports rspN_valid  out  1  one-cycle response strobe.
REQ-012 SHALL have ports rspN_rdata  out  32  load result, otherwise 0.
REQ-013 SHALL have ports rspN_err  out  1  misaligned, out-of-range or illegal ctrl.
REQ-014 SHALL have ports mem_addr  out  32, mem_wdata  out  32, mem_ctrl  out  3, mem_wen  out  1, all driving dmem.
REQ-015 SHALL have port mem_rdata  in  32  dmem combinational read data (dmem outdata).

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, with one cycle in each of ACCESS and RESP.
REQ-017 In IDLE, reqN_ready SHALL be asserted combinationally to the arbitration winner only; a handshake occurs when valid && ready; request fields SHALL be latched; next state is ACCESS.
REQ-018 Arbitration with DEBUG_PRIO=0: round-robin on last_grant; single requester always wins; with both valid, the one not granted last wins.
REQ-019 Arbitration with DEBUG_PRIO=1: req1 always wins when both are valid.
REQ-020 reqN_ready SHALL be 0 in ACCESS and RESP; requesters hold valid and fields stable until ready.
REQ-021 err SHALL be set for: H/HU with addr[0]=1; W with addr[1:0]!=0; ctrl in {011,110,111}; stores with ctrl not in {000,001,010}; addr+size > MEM_BYTES.
REQ-022 In ACCESS, mem_* SHALL carry the latched request; mem_wen SHALL = latched wen && !err; mem_rdata SHALL be captured at the end of the cycle.
REQ-023 Outside ACCESS, or when err is set, mem_addr/mem_wdata/mem_ctrl SHALL be 0 and mem_wen SHALL be 0.
REQ-024 In RESP, rspN_valid SHALL be 1 for the granted N only; rdata = captured data for loads without err, else 0.
REQ-025 Latency SHALL be: handshake in cycle T, mem access in T+1, rsp_valid in T+2; next handshake no earlier than T+3.
REQ-026 rsp outputs SHALL be registered; rdata/err SHALL hold their value until the next RESP; rsp_valid SHALL be low outside RESP.

Reset
REQ-027 On RST_N low (asynchronous), the block SHALL go to IDLE with last_grant=1, so req0 wins the first tie.
REQ-028 On reset, all rsp outputs SHALL be 0 and all latched fields SHALL be 0.
REQ-029 mem_wen SHALL drop immediately on reset assertion; an in-flight request is discarded with no response.
REQ-030 After RST_N deasserts, the first handshake SHALL be possible on the first rising edge.

Structure
REQ-031 Shared package dmem_pkg SHALL hold: funct3 encodings, FSM state enum and the MEM_BYTES default.
REQ-032 Misalignment/range/ctrl checking SHALL be a combinational sub-module dmem_acc_chk (inputs addr, ctrl, wen; output err).

Verification
REQ-033 Scenario: req0 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> mem_wen=1 only in T+1; load rsp0_rdata=0xDEADBEEF at T+2, err=0.
REQ-034 Scenario: req0 LH addr 0x13 -> rsp0_err=1, rdata=0, mem_wen never 1, rsp at T+2.
REQ-035 Scenario: req0 and req1 valid continuously, DEBUG_PRIO=0 -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-036 Scenario: DEBUG_PRIO=1, both valid -> req1 granted every time; req0 ready stays 0.
REQ-037 Scenario: SB addr 0x1000 with MEM_BYTES=4096 -> err=1, no write; illegal ctrl 011 load -> err=1.
REQ-038 Scenario: RST_N pulled low during ACCESS of a store -> mem_wen=0 at once, no rsp_valid, FSM in IDLE after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and defaults for the data-memory arbiter
package dmem_pkg;

    localparam int unsigned MEM_BYTES_DEF = 4096;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Access width in bytes; illegal encodings report 1 and are rejected by the ctrl check.
    function automatic logic [2:0] acc_size(input logic [2:0] ctrl);
        case (ctrl)
            F3_H, F3_HU: acc_size = 3'd2;
            F3_W:        acc_size = 3'd4;
            default:     acc_size = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_acc_chk.sv
// rtl/dmem_acc_chk.sv - combinational alignment, range and funct3 legality check
module dmem_acc_chk
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic [31:0] addr,
    input  logic [2:0]  ctrl,
    input  logic        wen,
    output logic        err
);

    logic        ctrl_bad;
    logic        misalign;
    logic        out_of_range;
    logic [32:0] end_addr;

    always_comb begin
        ctrl_bad = 1'b0;
        misalign = 1'b0;
        case (ctrl)
            F3_B:        ctrl_bad = 1'b0;
            F3_H:        misalign = addr[0];
            F3_W:        misalign = (addr[1:0] != 2'b00);
            F3_BU:       ctrl_bad = wen;
            F3_HU: begin
                ctrl_bad = wen;
                misalign = addr[0];
            end
            default:     ctrl_bad = 1'b1;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap back into range
        end_addr     = {1'b0, addr} + {30'd0, acc_size(ctrl)};
        out_of_range = (end_addr > 33'(MEM_BYTES));
        err          = ctrl_bad || misalign || out_of_range;
    end

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - two-requester data-memory arbiter with one access in flight at a time
module dmem_arb
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
    parameter bit          DEBUG_PRIO = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [2:0]  req0_ctrl,
    input  logic        req0_wen,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [2:0]  req1_ctrl,
    input  logic        req1_wen,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_ctrl,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        gnt_id;
    logic        win;
    logic        hs;
    logic        acc_err;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_ctrl;
    logic        lat_wen;
    logic [31:0] load_data;

    dmem_acc_chk #(.MEM_BYTES(MEM_BYTES)) u_chk (
        .addr (lat_addr),
        .ctrl (lat_ctrl),
        .wen  (lat_wen),
        .err  (acc_err)
    );

    // win: 0 selects req0, 1 selects req1; a lone requester always wins
    always_comb begin
        win = req1_valid;
        if (req0_valid && req1_valid) begin
            win = DEBUG_PRIO ? 1'b1 : ~last_grant;
        end
        req0_ready = (state == ST_IDLE) && req0_valid && !win;
        req1_ready = (state == ST_IDLE) && req1_valid && win;
        hs         = req0_ready || req1_ready;

        state_nxt = state;
        case (state)
            ST_IDLE:   if (hs) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // The memory bus is quiet outside ACCESS, so reset kills a pending store immediately.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ctrl  = '0;
        mem_wen   = 1'b0;
        if (state == ST_ACCESS && !acc_err) begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_ctrl  = lat_ctrl;
            mem_wen   = lat_wen;
        end
        load_data = (!lat_wen && !acc_err) ? mem_rdata : 32'd0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_ctrl   <= '0;
            lat_wen    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                last_grant <= win;
                gnt_id     <= win;
                lat_addr   <= win ? req1_addr  : req0_addr;
                lat_wdata  <= win ? req1_wdata : req0_wdata;
                lat_ctrl   <= win ? req1_ctrl  : req0_ctrl;
                lat_wen    <= win ? req1_wen   : req0_wen;
            end
        end
    end

    // Response registers load at the end of ACCESS; data and err hold until that port's next response.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (state == ST_ACCESS) begin
                if (gnt_id) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= load_data;
                    rsp1_err   <= acc_err;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= load_data;
                    rsp0_err   <= acc_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - randomized and directed bench for dmem_arb against a transaction-level model
module tb_dmem_arb;
    import dmem_pkg::*;

    localparam int MEMB = 4096;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    int          sel;
    logic        mem_init;
    logic        chk_on;
    logic [1:0]  rv;
    logic [31:0] raddr [2];
    logic [31:0] rwdata [2];
    logic [2:0]  rctrl [2];
    logic [1:0]  rwen;
    logic [31:0] mem_rdata;

    logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_err0, a_err1, a_mwen;
    logic [31:0] a_rd0, a_rd1, a_maddr, a_mwdata;
    logic [2:0]  a_mctrl;
    logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_err0, b_err1, b_mwen;
    logic [31:0] b_rd0, b_rd1, b_maddr, b_mwdata;
    logic [2:0]  b_mctrl;

    dmem_arb #(.MEM_BYTES(MEMB), .DEBUG_PRIO(1'b0)) u_rr (
        .CLK(CLK), .RST_N(RST_N),
        .req0_valid(rv[0] && sel == 0), .req0_ready(a_rdy0), .req0_addr(raddr[0]),
        .req0_wdata(rwdata[0]), .req0_ctrl(rctrl[0]), .req0_wen(rwen[0]),
        .req1_valid(rv[1] && sel == 0), .req1_ready(a_rdy1), .req1_addr(raddr[1]),
        .req1_wdata(rwdata[1]), .req1_ctrl(rctrl[1]), .req1_wen(rwen[1]),
        .rsp0_valid(a_rv0), .rsp0_rdata(a_rd0), .rsp0_err(a_err0),
        .rsp1_valid(a_rv1), .rsp1_rdata(a_rd1), .rsp1_err(a_err1),
        .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_ctrl(a_mctrl), .mem_wen(a_mwen),
        .mem_rdata(mem_rdata)
    );

    dmem_arb #(.MEM_BYTES(MEMB), .DEBUG_PRIO(1'b1)) u_fp (
        .CLK(CLK), .RST_N(RST_N),
        .req0_valid(rv[0] && sel == 1), .req0_ready(b_rdy0), .req0_addr(raddr[0]),
        .req0_wdata(rwdata[0]), .req0_ctrl(rctrl[0]), .req0_wen(rwen[0]),
        .req1_valid(rv[1] && sel == 1), .req1_ready(b_rdy1), .req1_addr(raddr[1]),
        .req1_wdata(rwdata[1]), .req1_ctrl(rctrl[1]), .req1_wen(rwen[1]),
        .rsp0_valid(b_rv0), .rsp0_rdata(b_rd0), .rsp0_err(b_err0),
        .rsp1_valid(b_rv1), .rsp1_rdata(b_rd1), .rsp1_err(b_err1),
        .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_ctrl(b_mctrl), .mem_wen(b_mwen),
        .mem_rdata(mem_rdata)
    );

    logic [1:0]  d_ready, d_rspv, d_err;
    logic [31:0] d_rd [2];
    logic [31:0] d_maddr, d_mwdata;
    logic [2:0]  d_mctrl;
    logic        d_mwen;

    always_comb begin
        d_ready  = (sel == 0) ? {a_rdy1, a_rdy0} : {b_rdy1, b_rdy0};
        d_rspv   = (sel == 0) ? {a_rv1, a_rv0}   : {b_rv1, b_rv0};
        d_err    = (sel == 0) ? {a_err1, a_err0} : {b_err1, b_err0};
        d_rd[0]  = (sel == 0) ? a_rd0 : b_rd0;
        d_rd[1]  = (sel == 0) ? a_rd1 : b_rd1;
        d_maddr  = (sel == 0) ? a_maddr  : b_maddr;
        d_mwdata = (sel == 0) ? a_mwdata : b_mwdata;
        d_mctrl  = (sel == 0) ? a_mctrl  : b_mctrl;
        d_mwen   = (sel == 0) ? a_mwen   : b_mwen;
    end

    // Bench-side dmem: combinational read with funct3 extension, byte-lane writes on the clock.
    logic [7:0]  dmem [MEMB];
    logic [11:0] ia;
    logic [7:0]  b0, b1, b2, b3;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    always_comb begin
        ia = d_maddr[11:0];
        b0 = dmem[ia];
        b1 = dmem[ia + 12'd1];
        b2 = dmem[ia + 12'd2];
        b3 = dmem[ia + 12'd3];
        case (d_mctrl)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rdata = {b3, b2, b1, b0};
            3'b100:  mem_rdata = {24'd0, b0};
            3'b101:  mem_rdata = {16'd0, b1, b0};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < MEMB; i++) dmem[i] <= init_byte(i);
        end else if (d_mwen) begin
            dmem[d_maddr[11:0]] <= d_mwdata[7:0];
            if (d_mctrl != 3'b000) dmem[d_maddr[11:0] + 12'd1] <= d_mwdata[15:8];
            if (d_mctrl == 3'b010) begin
                dmem[d_maddr[11:0] + 12'd2] <= d_mwdata[23:16];
                dmem[d_maddr[11:0] + 12'd3] <= d_mwdata[31:24];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction described by its handshake cycle.
    logic [7:0]  ref_mem [MEMB];
    int          cyc = 0;
    int          hs_cyc = -10;
    int          last = 1;
    int          m_ph, m_win;
    bit          m_idle;
    int          t_id;
    logic [31:0] t_addr, t_wdata;
    logic [2:0]  t_ctrl;
    bit          t_wen, t_err;
    logic [31:0] exp_rd [2];
    bit   [1:0]  exp_er;
    bit   [1:0]  e_rdy, e_rspv;
    logic [31:0] e_maddr, e_mwdata;
    logic [2:0]  e_mctrl;
    bit          e_mwen;
    int          grants[$];

    function automatic int sz_of(input logic [2:0] c);
        return (c == 3'b001 || c == 3'b101) ? 2 : (c == 3'b010) ? 4 : 1;
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] c, input bit w);
        int sz = sz_of(c);
        bit ok_ld = (c == 3'd0 || c == 3'd1 || c == 3'd2 || c == 3'd4 || c == 3'd5);
        bit ok_st = (c == 3'd0 || c == 3'd1 || c == 3'd2);
        if (w ? !ok_st : !ok_ld) return 1'b1;
        if ((a % sz) != 0) return 1'b1;
        if (longint'({32'd0, a}) + sz > MEMB) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
        longint v = 0;
        int sz = sz_of(c);
        for (int k = sz - 1; k >= 0; k--) v = v * 256 + ref_mem[int'(a) + k];
        if (c[2] == 1'b0 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    always @(negedge CLK) begin
        if (mem_init) for (int i = 0; i < MEMB; i++) ref_mem[i] = init_byte(i);
        if (!RST_N) begin
            hs_cyc = -10;
            last   = 1;
            exp_rd[0] = 0;
            exp_rd[1] = 0;
            exp_er    = 0;
            if (chk_on) begin
                chk("rst_rspv", d_rspv, 0);
                chk("rst_rdata0", d_rd[0], 0);
                chk("rst_rdata1", d_rd[1], 0);
                chk("rst_err", d_err, 0);
                chk("rst_mem_wen", d_mwen, 0);
            end
        end else if (chk_on) begin
            m_ph   = cyc - hs_cyc;
            m_idle = (m_ph >= 3);
            if (rv[0] && rv[1]) m_win = (sel == 1) ? 1 : (last == 1 ? 0 : 1);
            else                m_win = rv[1] ? 1 : 0;
            e_rdy[0] = m_idle && rv[0] && m_win == 0;
            e_rdy[1] = m_idle && rv[1] && m_win == 1;
            e_maddr = 0; e_mwdata = 0; e_mctrl = 0; e_mwen = 0;
            if (m_ph == 1 && !t_err) begin
                e_maddr = t_addr; e_mwdata = t_wdata; e_mctrl = t_ctrl; e_mwen = t_wen;
            end
            e_rspv = 0;
            if (m_ph == 2) begin
                e_rspv[t_id] = 1'b1;
                exp_er[t_id] = t_err;
                exp_rd[t_id] = (!t_wen && !t_err) ? ref_load(t_addr, t_ctrl) : 32'd0;
                if (t_wen && !t_err)
                    for (int k = 0; k < sz_of(t_ctrl); k++) ref_mem[int'(t_addr) + k] = 8'(t_wdata >> (8 * k));
            end
            chk("ready", d_ready, e_rdy);
            chk("mem_addr", d_maddr, e_maddr);
            chk("mem_wdata", d_mwdata, e_mwdata);
            chk("mem_ctrl", d_mctrl, e_mctrl);
            chk("mem_wen", d_mwen, e_mwen);
            chk("rsp_valid", d_rspv, e_rspv);
            chk("rsp0_rdata", d_rd[0], exp_rd[0]);
            chk("rsp1_rdata", d_rd[1], exp_rd[1]);
            chk("rsp_err", d_err, exp_er);
            if (m_idle && (rv[0] || rv[1])) begin
                t_id    = m_win;
                t_addr  = raddr[m_win];
                t_wdata = rwdata[m_win];
                t_ctrl  = rctrl[m_win];
                t_wen   = rwen[m_win];
                t_err   = model_err(t_addr, t_ctrl, t_wen);
                hs_cyc  = cyc;
                last    = m_win;
                grants.push_back(m_win);
            end
        end
        cyc++;
    end

    task automatic do_req(input int n, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] c, input logic w, output int waits);
        bit got = 0;
        rv[n] = 1'b1; raddr[n] = a; rwdata[n] = wd; rctrl[n] = c; rwen[n] = w;
        waits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (d_ready[n]) begin
                got = 1;
                break;
            end
            waits++;
            @(posedge CLK); #1;
        end
        chk("handshake", 32'(got), 1);
        @(posedge CLK); #1;
        rv[n] = 1'b0;
    endtask

    task automatic txn(input string nm, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] c,
                       input logic w, input logic [31:0] e_rd, input bit e_er, input bit e_we);
        int waits;
        do_req(0, a, wd, c, w, waits);
        @(negedge CLK);
        chk({nm, "_t1_wen"}, d_mwen, e_we);
        @(negedge CLK);
        chk({nm, "_t2_rspv"}, d_rspv, 2'b01);
        chk({nm, "_t2_rdata"}, d_rd[0], e_rd);
        chk({nm, "_t2_err"}, d_err[0], e_er);
        @(posedge CLK); #1;
    endtask

    task automatic new_req(input int n);
        int r = $urandom % 10;
        rv[n]     = 1'b1;
        raddr[n]  = (r < 6) ? 32'($urandom % 64) : (r < 8) ? 32'(4088 + $urandom % 12) : 32'($urandom);
        rwdata[n] = $urandom;
        rctrl[n]  = 3'($urandom % 8);
        rwen[n]   = 1'($urandom % 2);
    endtask

    task automatic run_random(input int s);
        bit [1:0] hs;
        rv = 0;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        sel   = s;
        @(negedge CLK);
        @(posedge CLK); #1;
        grants.delete();
        RST_N = 1'b1;
        new_req(0);
        new_req(1);
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            hs = rv & d_ready;
            @(posedge CLK); #1;
            for (int n = 0; n < 2; n++)
                if (hs[n] || !rv[n]) begin
                    if (i < 40 || ($urandom % 3) != 0) new_req(n);
                    else rv[n] = 1'b0;
                end
        end
        rv = 0;
        repeat (4) @(posedge CLK);
        #1;
        chk("grant_count", 32'(grants.size() >= 4), 1);
        if (grants.size() >= 4)
            for (int k = 0; k < 4; k++)
                chk($sformatf("grant%0d_prio%0d", k, s), grants[k], (s == 1) ? 1 : k % 2);
    endtask

    initial begin
        int w;
        sel = 0; rv = 0; rwen = 0; chk_on = 0; mem_init = 1; RST_N = 0;
        for (int n = 0; n < 2; n++) begin
            raddr[n] = 0; rwdata[n] = 0; rctrl[n] = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
        #1 mem_init = 0;
        chk_on = 1;
        @(negedge CLK);
        chk("reset_rspv", d_rspv, 0);
        chk("reset_rdata0", d_rd[0], 0);
        @(posedge CLK); #1;
        RST_N = 1;

        do_req(0, 32'h40, 0, 3'b000, 1'b0, w);
        chk("first_edge_handshake", w, 0);
        repeat (2) @(posedge CLK);
        #1;
        txn("sw",   32'h10,   32'hDEADBEEF, 3'b010, 1'b1, 32'h0,        1'b0, 1'b1);
        txn("lw",   32'h10,   32'h0,        3'b010, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        txn("lh",   32'h13,   32'h0,        3'b001, 1'b0, 32'h0,        1'b1, 1'b0);
        txn("sb_oor", 32'h1000, 32'h55,     3'b000, 1'b1, 32'h0,        1'b1, 1'b0);
        txn("ld011", 32'h20,  32'h0,        3'b011, 1'b0, 32'h0,        1'b1, 1'b0);
        txn("sb",   32'h30,   32'h12345680, 3'b000, 1'b1, 32'h0,        1'b0, 1'b1);
        txn("lb",   32'h30,   32'h0,        3'b000, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0);
        txn("lbu",  32'h30,   32'h0,        3'b100, 1'b0, 32'h00000080, 1'b0, 1'b0);

        do_req(0, 32'h40, 32'hCAFEF00D, 3'b010, 1'b1, w);
        @(negedge CLK);
        chk("rst_store_t1_wen", d_mwen, 1);
        #2 RST_N = 0;
        #1 chk("rst_wen_drop", d_mwen, 0);
        @(negedge CLK);
        @(posedge CLK); #1;
        RST_N = 1;
        txn("lw_after_rst", 32'h40, 32'h0, 3'b010, 1'b0, 32'hBA95704B, 1'b0, 1'b0);

        run_random(0);
        run_random(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
